// File: rtl/hdmi_rx_decoder_if.sv
// Bundle of aligned TMDS symbol inputs and recovered video/island outputs
// of the HDMI receive decoder.
interface hdmi_rx_decoder_if;
  logic [9:0]  SYM0;
  logic [9:0]  SYM1;
  logic [9:0]  SYM2;
  logic        HSYNC;
  logic        VSYNC;
  logic [3:0]  CTL;
  logic        VDE;
  logic [23:0] VIDDATA;
  logic        ADE;
  logic [11:0] AUXDATA;
  logic [4:0]  PKTIDX;
  logic [31:0] HEADER;
  logic        HDRVALID;
  logic        ERR;

  modport master (
    output SYM0, SYM1, SYM2,
    input  HSYNC, VSYNC, CTL, VDE, VIDDATA, ADE, AUXDATA, PKTIDX, HEADER, HDRVALID, ERR
  );

  modport slave (
    input  SYM0, SYM1, SYM2,
    output HSYNC, VSYNC, CTL, VDE, VIDDATA, ADE, AUXDATA, PKTIDX, HEADER, HDRVALID, ERR
  );
endinterface

// File: rtl/hdmi_rx_decoder.sv
// HDMI receive decoder: classifies each pixel-clock cycle of three TMDS symbols
// and recovers syncs, control bits, video pixels, TERC4 nibbles and packet headers.
module hdmi_rx_decoder #(
  parameter int MAX_PACKETS  = 18,
  parameter int MIN_PREAMBLE = 8
) (
  input logic              CLK,
  input logic              RST,
  hdmi_rx_decoder_if.slave bus
);
  typedef enum logic [2:0] {CTRL, VID_GB, VIDEO, AUX_GB_L, ISLAND, AUX_GB_T} state_t;
  typedef enum logic [1:0] {PRE_NONE, PRE_VID, PRE_AUX} pre_t;

  localparam logic [9:0] GB_A    = 10'b1011001100;
  localparam logic [9:0] GB_B    = 10'b0100110011;
  localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);
  localparam logic [4:0] MAX_PKT = 5'(MAX_PACKETS);

  // Returns {valid, d1, d0}
  function automatic logic [2:0] ctrl_dec(input logic [9:0] s);
    case (s)
      10'b1101010100: ctrl_dec = 3'b100;
      10'b0010101011: ctrl_dec = 3'b101;
      10'b0101010100: ctrl_dec = 3'b110;
      10'b1010101011: ctrl_dec = 3'b111;
      default:        ctrl_dec = 3'b000;
    endcase
  endfunction

  // Returns {valid, nibble}; invalid symbols decode to nibble 0
  function automatic logic [4:0] terc4_dec(input logic [9:0] s);
    case (s)
      10'b1010011100: terc4_dec = 5'h10;
      10'b1001100011: terc4_dec = 5'h11;
      10'b1011100100: terc4_dec = 5'h12;
      10'b1011100010: terc4_dec = 5'h13;
      10'b0101110001: terc4_dec = 5'h14;
      10'b0100011110: terc4_dec = 5'h15;
      10'b0110001110: terc4_dec = 5'h16;
      10'b0100111100: terc4_dec = 5'h17;
      10'b1011001100: terc4_dec = 5'h18;
      10'b0100111001: terc4_dec = 5'h19;
      10'b0110011100: terc4_dec = 5'h1A;
      10'b1011000110: terc4_dec = 5'h1B;
      10'b1010001110: terc4_dec = 5'h1C;
      10'b1001110001: terc4_dec = 5'h1D;
      10'b0101100011: terc4_dec = 5'h1E;
      10'b1011000011: terc4_dec = 5'h1F;
      default:        terc4_dec = 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = q[9] ? ~q[7:0] : q[7:0];
    d[0] = dp[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    end
    return d;
  endfunction

  state_t      state, nxt_state;
  pre_t        pre_kind, nxt_pre_kind, cur_pre;
  logic [3:0]  precnt, nxt_precnt;
  logic [4:0]  idx, nxt_idx, use_idx;
  logic        pkt_end, nxt_pkt_end;
  logic [4:0]  pkt_cnt, nxt_pkt_cnt;
  logic [30:0] hdr_acc, nxt_hdr_acc;

  logic        hsync, vsync, vde, ade, hdrvalid, err;
  logic        nxt_hsync, nxt_vsync, nxt_vde, nxt_ade, nxt_hdrvalid, nxt_err;
  logic [3:0]  ctl, nxt_ctl;
  logic [23:0] viddata, nxt_viddata;
  logic [11:0] auxdata, nxt_auxdata;
  logic [4:0]  pktidx, nxt_pktidx;
  logic [31:0] header, nxt_header;

  logic [2:0]  c0, c1, c2;
  logic [4:0]  t0, t1, t2;
  logic        vgb, igb, bad_sym, bad_frm;

  assign bus.HSYNC    = hsync;
  assign bus.VSYNC    = vsync;
  assign bus.CTL      = ctl;
  assign bus.VDE      = vde;
  assign bus.VIDDATA  = viddata;
  assign bus.ADE      = ade;
  assign bus.AUXDATA  = auxdata;
  assign bus.PKTIDX   = pktidx;
  assign bus.HEADER   = header;
  assign bus.HDRVALID = hdrvalid;
  assign bus.ERR      = err;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= CTRL;
      pre_kind <= PRE_NONE;
      precnt   <= 4'd0;
      idx      <= 5'd0;
      pkt_end  <= 1'b0;
      pkt_cnt  <= 5'd0;
      hdr_acc  <= 31'd0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      ctl      <= 4'd0;
      vde      <= 1'b0;
      viddata  <= 24'd0;
      ade      <= 1'b0;
      auxdata  <= 12'd0;
      pktidx   <= 5'd0;
      header   <= 32'd0;
      hdrvalid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= nxt_state;
      pre_kind <= nxt_pre_kind;
      precnt   <= nxt_precnt;
      idx      <= nxt_idx;
      pkt_end  <= nxt_pkt_end;
      pkt_cnt  <= nxt_pkt_cnt;
      hdr_acc  <= nxt_hdr_acc;
      hsync    <= nxt_hsync;
      vsync    <= nxt_vsync;
      ctl      <= nxt_ctl;
      vde      <= nxt_vde;
      viddata  <= nxt_viddata;
      ade      <= nxt_ade;
      auxdata  <= nxt_auxdata;
      pktidx   <= nxt_pktidx;
      header   <= nxt_header;
      hdrvalid <= nxt_hdrvalid;
      err      <= nxt_err;
    end
  end

  // Symbol classification, next-state and next-output logic
  always_comb begin
    c0  = ctrl_dec(bus.SYM0);
    c1  = ctrl_dec(bus.SYM1);
    c2  = ctrl_dec(bus.SYM2);
    t0  = terc4_dec(bus.SYM0);
    t1  = terc4_dec(bus.SYM1);
    t2  = terc4_dec(bus.SYM2);
    vgb = (bus.SYM0 == GB_A) && (bus.SYM1 == GB_B) && (bus.SYM2 == GB_A);
    igb = (bus.SYM1 == GB_B) && (bus.SYM2 == GB_B) && t0[4] && (t0[3:2] == 2'b11);

    if (c1[2] && (c1[1:0] == 2'b01) && c2[2] && (c2[1:0] == 2'b00)) begin
      cur_pre = PRE_VID;
    end else if (c1[2] && (c1[1:0] == 2'b01) && c2[2] && (c2[1:0] == 2'b01)) begin
      cur_pre = PRE_AUX;
    end else begin
      cur_pre = PRE_NONE;
    end

    nxt_state    = state;
    nxt_pre_kind = PRE_NONE;
    nxt_precnt   = 4'd0;
    nxt_idx      = idx;
    nxt_pkt_end  = pkt_end;
    nxt_pkt_cnt  = pkt_cnt;
    nxt_hdr_acc  = hdr_acc;
    nxt_hsync    = hsync;
    nxt_vsync    = vsync;
    nxt_ctl      = ctl;
    nxt_vde      = 1'b0;
    nxt_viddata  = viddata;
    nxt_ade      = 1'b0;
    nxt_auxdata  = auxdata;
    nxt_pktidx   = pktidx;
    nxt_header   = header;
    nxt_hdrvalid = 1'b0;
    nxt_err      = 1'b0;
    use_idx      = 5'd0;
    bad_sym      = 1'b0;
    bad_frm      = 1'b0;

    case (state)
      CTRL: begin
        if (vgb) begin
          if ((precnt >= MIN_PRE) && (pre_kind == PRE_VID)) begin
            nxt_state = VID_GB;
          end else begin
            nxt_err = 1'b1;
          end
        end else if (igb) begin
          if ((precnt >= MIN_PRE) && (pre_kind == PRE_AUX)) begin
            nxt_state = AUX_GB_L;
            nxt_hsync = t0[0];
            nxt_vsync = t0[1];
          end else begin
            nxt_err = 1'b1;
          end
        end else begin
          if (c0[2]) begin
            {nxt_vsync, nxt_hsync} = c0[1:0];
          end else begin
            nxt_err = 1'b1;
          end
          if (c1[2]) begin
            nxt_ctl[1:0] = c1[1:0];
          end else begin
            nxt_ctl[1:0] = ctl[1:0];
          end
          if (c2[2]) begin
            nxt_ctl[3:2] = c2[1:0];
          end else begin
            nxt_ctl[3:2] = ctl[3:2];
          end
          // A kind change (including from "none") restarts the run at 1
          if (cur_pre == PRE_NONE) begin
            nxt_precnt   = 4'd0;
            nxt_pre_kind = PRE_NONE;
          end else if (cur_pre == pre_kind) begin
            nxt_precnt   = (precnt == 4'd15) ? 4'd15 : precnt + 4'd1;
            nxt_pre_kind = cur_pre;
          end else begin
            nxt_precnt   = 4'd1;
            nxt_pre_kind = cur_pre;
          end
        end
      end

      VID_GB: begin
        if (vgb) begin
          nxt_state = VIDEO;
        end else begin
          nxt_state = CTRL;
          nxt_err   = 1'b1;
        end
      end

      VIDEO: begin
        if (c0[2]) begin
          nxt_state              = CTRL;
          {nxt_vsync, nxt_hsync} = c0[1:0];
          if (c1[2]) begin
            nxt_ctl[1:0] = c1[1:0];
          end else begin
            nxt_ctl[1:0] = ctl[1:0];
          end
          if (c2[2]) begin
            nxt_ctl[3:2] = c2[1:0];
          end else begin
            nxt_ctl[3:2] = ctl[3:2];
          end
        end else begin
          nxt_vde     = 1'b1;
          nxt_viddata = {tmds_dec(bus.SYM2), tmds_dec(bus.SYM1), tmds_dec(bus.SYM0)};
        end
      end

      AUX_GB_L: begin
        if (igb) begin
          nxt_state   = ISLAND;
          nxt_hsync   = t0[0];
          nxt_vsync   = t0[1];
          nxt_idx     = 5'd0;
          nxt_pkt_end = 1'b0;
          nxt_pkt_cnt = 5'd1;
        end else begin
          nxt_state = CTRL;
          nxt_err   = 1'b1;
        end
      end

      ISLAND: begin
        // pkt_end marks the cycle right after a packet's final symbol
        if (pkt_end && igb) begin
          nxt_state   = AUX_GB_T;
          nxt_hsync   = t0[0];
          nxt_vsync   = t0[1];
          nxt_pkt_end = 1'b0;
        end else if (pkt_end && (pkt_cnt >= MAX_PKT)) begin
          nxt_state   = CTRL;
          nxt_err     = 1'b1;
          nxt_pkt_end = 1'b0;
        end else begin
          use_idx = pkt_end ? 5'd0 : idx;
          if (pkt_end) begin
            nxt_pkt_cnt = pkt_cnt + 5'd1;
          end else begin
            nxt_pkt_cnt = pkt_cnt;
          end
          nxt_ade     = 1'b1;
          nxt_auxdata = {t2[3:0], t1[3:0], t0[3:0]};
          nxt_pktidx  = use_idx;
          nxt_hsync   = t0[0];
          nxt_vsync   = t0[1];
          bad_sym     = !(t0[4] && t1[4] && t2[4]);
          bad_frm     = (use_idx == 5'd0) ? t0[3] : !t0[3];
          nxt_err     = bad_sym || bad_frm;
          if (use_idx == 5'd31) begin
            nxt_header   = {t0[2], hdr_acc};
            nxt_hdrvalid = 1'b1;
            nxt_pkt_end  = 1'b1;
            nxt_idx      = 5'd0;
          end else begin
            nxt_hdr_acc[use_idx] = t0[2];
            nxt_pkt_end          = 1'b0;
            nxt_idx              = use_idx + 5'd1;
          end
        end
      end

      AUX_GB_T: begin
        nxt_state = CTRL;
        if (igb) begin
          nxt_hsync = t0[0];
          nxt_vsync = t0[1];
        end else begin
          nxt_err = 1'b1;
        end
      end

      default: begin
        nxt_state = CTRL;
      end
    endcase
  end
endmodule

// File: doc/hdmi_rx_decoder.md
# hdmi_rx_decoder

Receive-side counterpart of the HDMI transmit path. It takes three word-aligned 10-bit TMDS symbols per pixel clock from the deserializer and classifies each cycle as control, preamble, guard band, video or data island. It then decodes each class and recovers the timing and data signals: HSYNC, VSYNC, CTL[3:0], VDE, ADE, 24-bit pixels, TERC4 nibbles, and packet headers. It sits between the deserializer/aligner and the video sink and packet parser.

## Interface
- MAX_PACKETS, 18: packets allowed per data island before a trailing guard band is mandatory.
- MIN_PREAMBLE, 8: consecutive identical preamble cycles required before a guard band is accepted.
- CLK  in  1  pixel clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- SYM0, SYM1, SYM2  in  10 each  aligned TMDS symbols for channels 0/1/2; bit 0 is first on the wire.
- HSYNC, VSYNC  out  1  recovered sync levels; reset 0.
- CTL  out  4  {CTL3,CTL2,CTL1,CTL0} from ch2/ch1 control tokens; reset 0.
- VDE  out  1  video data valid; reset 0.
- VIDDATA  out  24  {ch2,ch1,ch0} decoded bytes; reset 0.
- ADE  out  1  data island symbol valid; reset 0.
- AUXDATA  out  12  {ch2,ch1,ch0} TERC4 nibbles; reset 0.
- PKTIDX  out  5  symbol index within the current packet (0..31); reset 0.
- HEADER  out  32  {ECC,HB2,HB1,HB0} of the last packet; reset 0.
- HDRVALID  out  1  one-cycle pulse when HEADER updates; reset 0.
- ERR  out  1  one-cycle pulse on a framing or symbol violation; reset 0.

## Operation
- Control tokens ({D1,D0}→symbol): 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011. Ch0 carries {VSYNC,HSYNC}, ch1 carries {CTL1,CTL0}, ch2 carries {CTL3,CTL2}.
- Preamble detection uses only ch1 and ch2:
  - Video preamble: ch1 token 01 and ch2 token 00.
  - Aux preamble: ch1 token 01 and ch2 token 01.
- Video guard band (VGB): ch0 1011001100, ch1 0100110011, ch2 1011001100.
- Island guard band (IGB): ch1 and ch2 both 0100110011; ch0 is TERC4 with nibble bits[3:2]=11.
- TERC4 decode, 0x0..0xF: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011. Any other symbol decodes to 0 and raises ERR.
- TMDS video decode:
  - d' = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = d'[0].
  - d[i] = q[8] ? d'[i]^d'[i-1] : ~(d'[i]^d'[i-1]).
- FSM states: CTRL, VID_GB, VIDEO, AUX_GB_L, ISLAND, AUX_GB_T.
- CTRL:
  - Ch0 must be a control token; it drives HSYNC/VSYNC. Otherwise ERR pulses and the sync outputs hold.
  - Ch1/ch2 tokens drive CTL.
  - PRECNT (saturating at 15) counts consecutive cycles with the same preamble kind. A kind change reloads it to 1; a non-preamble cycle clears it to 0.
  - VGB with PRECNT≥MIN_PREAMBLE of the video kind → VID_GB. IGB with PRECNT≥MIN_PREAMBLE of the aux kind → AUX_GB_L.
  - A guard band with an insufficient or mismatched preamble → ERR; stay in CTRL.
- VID_GB:
  - A second VGB → VIDEO.
  - Anything else → ERR, CTRL.
- VIDEO:
  - Each cycle decodes all three channels.
  - A control token on ch0 → CTRL. That symbol is treated as control: sync outputs update and VDE is not asserted for it.
- AUX_GB_L:
  - A second IGB → ISLAND with PKTIDX=0 and packet count 1.
  - Anything else → ERR, CTRL.
- ISLAND, each cycle:
  - TERC4-decode all channels.
  - HSYNC/VSYNC ← ch0 nibble [1:0].
  - Shift ch0 bit2 into the header at position PKTIDX, LSB first (HB0 = bits 0-7, ECC = bits 24-31). ECC is not checked.
  - Ch0 bit3 must be 0 at PKTIDX 0 and 1 at PKTIDX 1..31; a violation → ERR, but decoding continues.
  - At PKTIDX 31: HEADER updates and HDRVALID pulses. Then:
    - An IGB on the next cycle → AUX_GB_T.
    - Otherwise, with packet count < MAX_PACKETS, start the next packet (PKTIDX wraps to 0, count increments).
    - Otherwise → ERR, CTRL.
- AUX_GB_T:
  - A second IGB → CTRL.
  - Anything else → ERR, CTRL.
- Sync outputs during guard bands:
  - HSYNC/VSYNC hold during VIDEO and VID_GB.
  - HSYNC/VSYNC update from the ch0 TERC4 nibble in island guard bands.

## Timing
- All outputs are registered. A symbol sampled at edge k produces outputs visible after edge k, i.e. one cycle of latency.
- VDE/ADE are high exactly for the cycles that output VIDEO/ISLAND symbols. Guard band cycles output VDE=ADE=0.
- HDRVALID coincides with the output cycle of the PKTIDX=31 symbol.
- VIDDATA and AUXDATA hold their last value when invalid.
- While RST=0: the FSM goes to CTRL, PRECNT, PKTIDX and the packet count clear, and all outputs return to their reset values on the next edge, even mid-island.
- ERR pulses never stretch: consecutive errors give consecutive pulses.

## Test plan
- Video line: 8 video preambles, 2 VGB, 4 pixels encoding 0x00/0xFF/0xA5/0x3C per channel, then token 00 on ch0 → VDE high exactly 4 cycles after 1-cycle latency, VIDDATA matches, then HSYNC=VSYNC=0.
- Island, one packet: 8 aux preambles, 2 IGB, 32 symbols with header 0x00_0D_02_84, 2 IGB → ADE high for 32 cycles, PKTIDX 0..31, HDRVALID once with HEADER=0x000D0284, FSM ends in CTRL.
- Preamble of 7 cycles followed by VGB → ERR pulse; VDE stays 0.
- 18 back-to-back packets followed by a 19th with no IGB → ERR after packet 18; FSM returns to CTRL.
- Ch0 bit3=1 at PKTIDX 0 → single ERR pulse; HEADER is still delivered.
- RST low at PKTIDX 10 of an island → next cycle all outputs 0 and the FSM is in CTRL; a fresh preamble is needed to reacquire.
